// File: rtl/reg_rmw_seq_pkg.sv
// Shared definitions for the read-modify-write sequencer: opcodes, FSM states
// and data-width constants.
package reg_rmw_seq_pkg;

    localparam int BIT_DATA = 8;
    localparam int OFF      = 0;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_XOR  = 3'd4,
        OP_SHL1 = 3'd5,
        OP_SHR1 = 3'd6,
        OP_MOVI = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD_A = 3'd1,
        ST_RD_B = 3'd2,
        ST_EXEC = 3'd3,
        ST_WB   = 3'd4
    } state_e;

endpackage

// File: rtl/reg_rmw_seq_alu.sv
// Combinational 8-op ALU used in the sequencer's EXEC cycle; carry reports
// carry-out, unsigned borrow or the bit shifted out, depending on the opcode.
module rmw_alu
    import reg_rmw_seq_pkg::*;
#(
    parameter int BIT = BIT_DATA
) (
    input  op_e            op,
    input  logic [BIT-1:0] a,
    input  logic [BIT-1:0] b,
    input  logic [BIT-1:0] imm,
    output logic [BIT-1:0] result,
    output logic           carry
);

    logic [BIT:0] ext_sum;
    logic [BIT:0] ext_diff;

    // The extra top bit of a zero-extended subtraction is the unsigned borrow.
    assign ext_sum  = {1'b0, a} + {1'b0, b};
    assign ext_diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        result = '0;
        carry  = 1'b0;
        unique case (op)
            OP_ADD:  begin result = ext_sum[BIT-1:0];  carry = ext_sum[BIT];  end
            OP_SUB:  begin result = ext_diff[BIT-1:0]; carry = ext_diff[BIT]; end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_SHL1: begin result = {a[BIT-2:0], 1'b0}; carry = a[BIT-1]; end
            OP_SHR1: begin result = {1'b0, a[BIT-1:1]}; carry = a[0];     end
            OP_MOVI: result = imm;
        endcase
    end

endmodule

// File: rtl/reg_rmw_seq.sv
// Read-modify-write sequencer driving a single-port register file with registered
// read data. Optional RMW_NOWB_EN adds req_nowb to suppress the write-back.
module reg_rmw_seq
    import reg_rmw_seq_pkg::*;
#(
    parameter int BIT = BIT_DATA,
    parameter int SZB = 4
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [2:0]     req_op,
    input  logic [SZB-1:0] req_rs_a,
    input  logic [SZB-1:0] req_rs_b,
    input  logic [SZB-1:0] req_rd,
    input  logic [BIT-1:0] req_imm,
`ifdef RMW_NOWB_EN
    input  logic           req_nowb,
`endif
    output logic           rf_we,
    output logic [SZB-1:0] rf_addr,
    output logic [BIT-1:0] rf_din,
    input  logic [BIT-1:0] rf_dout,
    output logic           done,
    output logic [BIT-1:0] result,
    output logic           flag_z,
    output logic           flag_c
);

    state_e         state_q, state_d;
    op_e            op_q, op_d;
    logic [SZB-1:0] rs_a_q, rs_a_d;
    logic [SZB-1:0] rs_b_q, rs_b_d;
    logic [SZB-1:0] rd_q, rd_d;
    logic [BIT-1:0] imm_q, imm_d;
    logic [BIT-1:0] opa_q, opa_d;
    logic [BIT-1:0] result_q, result_d;
    logic           flag_z_q, flag_z_d;
    logic           flag_c_q, flag_c_d;
    logic           wb_inhibit;

    logic [BIT-1:0] alu_result;
    logic           alu_carry;

`ifdef RMW_NOWB_EN
    logic nowb_q, nowb_d;

    always_comb begin
        nowb_d = nowb_q;
        if (state_q == ST_IDLE && req_valid)
            nowb_d = req_nowb;
    end

    always_ff @(posedge clock) begin
        if (reset) nowb_q <= 1'b0;
        else       nowb_q <= nowb_d;
    end

    assign wb_inhibit = nowb_q;
`else
    assign wb_inhibit = 1'b0;
`endif

    // B operand arrives on rf_dout during EXEC, A was captured a cycle earlier.
    rmw_alu #(.BIT(BIT)) u_alu (
        .op     (op_q),
        .a      (opa_q),
        .b      (rf_dout),
        .imm    (imm_q),
        .result (alu_result),
        .carry  (alu_carry)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rs_a_d   = rs_a_q;
        rs_b_d   = rs_b_q;
        rd_d     = rd_q;
        imm_d    = imm_q;
        opa_d    = opa_q;
        result_d = result_q;
        flag_z_d = flag_z_q;
        flag_c_d = flag_c_q;
        case (state_q)
            ST_IDLE: if (req_valid) begin
                op_d    = op_e'(req_op);
                rs_a_d  = req_rs_a;
                rs_b_d  = req_rs_b;
                rd_d    = req_rd;
                imm_d   = req_imm;
                state_d = ST_RD_A;
            end
            ST_RD_A: state_d = ST_RD_B;
            ST_RD_B: begin
                opa_d   = rf_dout;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                result_d = alu_result;
                flag_z_d = (alu_result == '0);
                flag_c_d = alu_carry;
                state_d  = ST_WB;
            end
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_ADD;
            rs_a_q   <= '0;
            rs_b_q   <= '0;
            rd_q     <= '0;
            imm_q    <= '0;
            opa_q    <= '0;
            result_q <= '0;
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rs_a_q   <= rs_a_d;
            rs_b_q   <= rs_b_d;
            rd_q     <= rd_d;
            imm_q    <= imm_d;
            opa_q    <= opa_d;
            result_q <= result_d;
            flag_z_q <= flag_z_d;
            flag_c_q <= flag_c_d;
        end
    end

    // Reset gates the WB strobes combinationally so an abort in WB never writes.
    always_comb begin
        req_ready = 1'b0;
        rf_we     = 1'b0;
        rf_addr   = '0;
        rf_din    = '0;
        done      = 1'b0;
        case (state_q)
            ST_IDLE: req_ready = 1'b1;
            ST_RD_A: rf_addr = rs_a_q;
            ST_RD_B: rf_addr = rs_b_q;
            ST_EXEC: rf_addr = rs_b_q;
            ST_WB: begin
                rf_addr = rd_q;
                rf_din  = result_q;
                rf_we   = !reset && !wb_inhibit;
                done    = !reset;
            end
            default: ;
        endcase
    end

    assign result = result_q;
    assign flag_z = flag_z_q;
    assign flag_c = flag_c_q;

endmodule

// File: tb/tb_reg_rmw_seq.sv
// Directed self-checking bench for reg_rmw_seq with a behavioural register file
// (registered read, write on rf_we, bench-side preload port).
module tb_reg_rmw_seq;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [2:0] req_op = 3'd0;
    logic [3:0] req_rs_a = 4'd0;
    logic [3:0] req_rs_b = 4'd0;
    logic [3:0] req_rd = 4'd0;
    logic [7:0] req_imm = 8'd0;
`ifdef RMW_NOWB_EN
    logic       req_nowb = 1'b0;
`endif
    logic       rf_we;
    logic [3:0] rf_addr;
    logic [7:0] rf_din;
    logic [7:0] rf_dout;
    logic       done;
    logic [7:0] result;
    logic       flag_z;
    logic       flag_c;

    logic       rf_clear = 1'b1;
    logic       bd_we = 1'b0;
    logic [3:0] bd_addr = 4'd0;
    logic [7:0] bd_data = 8'd0;
    logic [7:0] mem [16];

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clock = ~clock;

    reg_rmw_seq #(.BIT(8), .SZB(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_rs_a  (req_rs_a),
        .req_rs_b  (req_rs_b),
        .req_rd    (req_rd),
        .req_imm   (req_imm),
`ifdef RMW_NOWB_EN
        .req_nowb  (req_nowb),
`endif
        .rf_we     (rf_we),
        .rf_addr   (rf_addr),
        .rf_din    (rf_din),
        .rf_dout   (rf_dout),
        .done      (done),
        .result    (result),
        .flag_z    (flag_z),
        .flag_c    (flag_c)
    );

    always @(posedge clock) begin
        if (rf_clear) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
        end else if (bd_we) begin
            mem[bd_addr] <= bd_data;
        end else if (rf_we) begin
            mem[rf_addr] <= rf_din;
        end
        rf_dout <= mem[rf_addr];
    end

    task automatic preload(input logic [3:0] a, input logic [7:0] d);
        @(negedge clock);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        @(posedge clock);
        #1 bd_we = 1'b0;
    endtask

    // Issues one request from IDLE, scrambles the request inputs after acceptance,
    // returns the done latency (cycles after the accept cycle) and the number of
    // write-enable cycles seen; returns with the write landed and the DUT idle.
    task automatic run_op(input logic [2:0] op, input logic [3:0] ra, input logic [3:0] rb,
                          input logic [3:0] rd, input logic [7:0] imm,
                          output int lat, output int we_cnt);
        @(negedge clock);
        req_op = op; req_rs_a = ra; req_rs_b = rb; req_rd = rd; req_imm = imm;
        req_valid = 1'b1;
        we_cnt = (rf_we === 1'b1) ? 1 : 0;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        req_op = ~op; req_rs_a = ~ra; req_rs_b = ~rb; req_rd = ~rd; req_imm = ~imm;
        lat = -1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clock);
            if (rf_we === 1'b1) we_cnt++;
            if (done === 1'b1) begin
                lat = i;
                break;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1 rf_clear = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b want 1", req_ready); end
        tests_run++; if (rf_we !== 1'b0) begin tests_failed++; $display("FAIL reset_we: got %b want 0", rf_we); end
        tests_run++; if (rf_addr !== 4'h0) begin tests_failed++; $display("FAIL reset_addr: got %h want 0", rf_addr); end
        tests_run++; if (rf_din !== 8'h00) begin tests_failed++; $display("FAIL reset_din: got %h want 00", rf_din); end
        tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b want 0", done); end
        tests_run++; if (result !== 8'h00) begin tests_failed++; $display("FAIL reset_result: got %h want 00", result); end
        tests_run++; if ({flag_z, flag_c} !== 2'b00) begin tests_failed++; $display("FAIL reset_flags: got zc=%b%b want 00", flag_z, flag_c); end
        $display("[TB] reset checked");
    endtask

    task automatic test_add;
        int lat, wc;
        preload(4'd1, 8'h80);
        preload(4'd2, 8'h80);
        run_op(3'd0, 4'd1, 4'd2, 4'd3, 8'h00, lat, wc);
        $display("[TB] ADD r1=80 r2=80 -> r3=%h z=%b c=%b lat=%0d", mem[3], flag_z, flag_c, lat);
        tests_run++; if (lat !== 4) begin tests_failed++; $display("FAIL add_latency: got %0d want 4", lat); end
        tests_run++; if (result !== 8'h00) begin tests_failed++; $display("FAIL add_result: got %h want 00", result); end
        tests_run++; if ({flag_z, flag_c} !== 2'b11) begin tests_failed++; $display("FAIL add_flags: got zc=%b%b want 11", flag_z, flag_c); end
        tests_run++; if (mem[3] !== 8'h00) begin tests_failed++; $display("FAIL add_r3: got %h want 00", mem[3]); end
        tests_run++; if (wc !== 1) begin tests_failed++; $display("FAIL add_we_count: got %0d want 1", wc); end
    endtask

    task automatic test_sub;
        int lat, wc;
        preload(4'd4, 8'h99);
        preload(4'd1, 8'h05);
        preload(4'd2, 8'h07);
        run_op(3'd1, 4'd1, 4'd2, 4'd4, 8'h00, lat, wc);
        $display("[TB] SUB 05-07 -> r4=%h z=%b c=%b", mem[4], flag_z, flag_c);
        tests_run++; if (mem[4] !== 8'hFE) begin tests_failed++; $display("FAIL sub_borrow_r4: got %h want FE", mem[4]); end
        tests_run++; if ({flag_z, flag_c} !== 2'b01) begin tests_failed++; $display("FAIL sub_borrow_flags: got zc=%b%b want 01", flag_z, flag_c); end
        preload(4'd1, 8'h07);
        run_op(3'd1, 4'd1, 4'd2, 4'd4, 8'h00, lat, wc);
        $display("[TB] SUB 07-07 -> r4=%h z=%b c=%b", mem[4], flag_z, flag_c);
        tests_run++; if (mem[4] !== 8'h00) begin tests_failed++; $display("FAIL sub_equal_r4: got %h want 00", mem[4]); end
        tests_run++; if ({flag_z, flag_c} !== 2'b10) begin tests_failed++; $display("FAIL sub_equal_flags: got zc=%b%b want 10", flag_z, flag_c); end
    endtask

    task automatic test_shr_hazard;
        int lat, wc;
        preload(4'd5, 8'h03);
        run_op(3'd6, 4'd5, 4'd2, 4'd5, 8'h00, lat, wc);
        $display("[TB] SHR1 r5=03 -> r5=%h c=%b", mem[5], flag_c);
        tests_run++; if (mem[5] !== 8'h01) begin tests_failed++; $display("FAIL shr_r5: got %h want 01", mem[5]); end
        tests_run++; if ({flag_z, flag_c} !== 2'b01) begin tests_failed++; $display("FAIL shr_flags: got zc=%b%b want 01", flag_z, flag_c); end
        preload(4'd5, 8'h81);
        run_op(3'd5, 4'd5, 4'd5, 4'd5, 8'h00, lat, wc);
        $display("[TB] SHL1 r5=81 -> r5=%h c=%b", mem[5], flag_c);
        tests_run++; if (mem[5] !== 8'h02) begin tests_failed++; $display("FAIL shl_r5: got %h want 02", mem[5]); end
        tests_run++; if (flag_c !== 1'b1) begin tests_failed++; $display("FAIL shl_carry: got %b want 1", flag_c); end
    endtask

    task automatic test_back_to_back;
        int acc [2];
        int acc_cnt = 0;
        @(negedge clock);
        req_op = 3'd7; req_imm = 8'h11; req_rd = 4'd7; req_rs_a = 4'd1; req_rs_b = 4'd2;
        req_valid = 1'b1;
        for (int cyc = 0; cyc < 14; cyc++) begin
            if (cyc > 0) @(negedge clock);
            if (req_valid && req_ready === 1'b1 && acc_cnt < 2) begin
                acc[acc_cnt] = cyc;
                acc_cnt++;
            end
            @(posedge clock);
            #1;
            if (acc_cnt == 1) begin
                req_imm = 8'h22; req_rd = 4'd8;
            end else if (acc_cnt == 2) begin
                req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        @(negedge clock);
        if (acc_cnt == 2) $display("[TB] back-to-back accepts at cycles %0d and %0d", acc[0], acc[1]);
        tests_run++;
        if (acc_cnt != 2) begin
            tests_failed++; $display("FAIL b2b_accepts: got %0d acceptances want 2", acc_cnt);
        end else if (acc[1] - acc[0] != 5) begin
            tests_failed++; $display("FAIL b2b_spacing: got %0d cycles want 5", acc[1] - acc[0]);
        end
        tests_run++; if (mem[7] !== 8'h11) begin tests_failed++; $display("FAIL b2b_r7: got %h want 11", mem[7]); end
        tests_run++; if (mem[8] !== 8'h22) begin tests_failed++; $display("FAIL b2b_r8: got %h want 22", mem[8]); end
    endtask

    task automatic test_movi_seq;
        logic [3:0] exp_addr [7];
        logic [3:0] got_addr [7];
        int we_cnt = 0;
        logic [7:0] wb_din = 8'h00;
        exp_addr = '{4'd0, 4'd3, 4'd9, 4'd9, 4'd15, 4'd0, 4'd0};
        @(negedge clock);
        req_op = 3'd7; req_rs_a = 4'd3; req_rs_b = 4'd9; req_rd = 4'd15; req_imm = 8'hA5;
        req_valid = 1'b1;
        got_addr[0] = rf_addr;
        if (rf_we === 1'b1) we_cnt++;
        @(posedge clock);
        #1;
        req_valid = 1'b0; req_rd = 4'd2; req_imm = 8'h00;
        for (int i = 1; i < 7; i++) begin
            @(negedge clock);
            got_addr[i] = rf_addr;
            if (rf_we === 1'b1) begin
                we_cnt++;
                wb_din = rf_din;
            end
        end
        $display("[TB] MOVI A5 -> r15=%h addr %h %h %h %h %h we_cycles=%0d", mem[15],
                 got_addr[0], got_addr[1], got_addr[2], got_addr[3], got_addr[4], we_cnt);
        for (int i = 0; i < 7; i++) begin
            tests_run++;
            if (got_addr[i] !== exp_addr[i]) begin
                tests_failed++; $display("FAIL movi_addr[%0d]: got %h want %h", i, got_addr[i], exp_addr[i]);
            end
        end
        tests_run++; if (we_cnt !== 1) begin tests_failed++; $display("FAIL movi_we_count: got %0d want 1", we_cnt); end
        tests_run++; if (wb_din !== 8'hA5) begin tests_failed++; $display("FAIL movi_din: got %h want A5", wb_din); end
        tests_run++; if (mem[15] !== 8'hA5) begin tests_failed++; $display("FAIL movi_r15: got %h want A5", mem[15]); end
    endtask

    task automatic test_reset_in_wb;
        int done_cnt = 0;
        logic we_in_wb;
        preload(4'd6, 8'h11);
        @(negedge clock);
        req_op = 3'd0; req_rs_a = 4'd1; req_rs_b = 4'd2; req_rd = 4'd6; req_imm = 8'h00;
        req_valid = 1'b1;
        @(posedge clock);
        #1 req_valid = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clock);
            if (done === 1'b1) done_cnt++;
        end
        @(negedge clock);
        we_in_wb = rf_we;
        reset = 1'b1;
        #1;
        if (done === 1'b1) done_cnt++;
        tests_run++; if (we_in_wb !== 1'b1) begin tests_failed++; $display("FAIL abort_reached_wb: got we=%b want 1", we_in_wb); end
        tests_run++; if (rf_we !== 1'b0) begin tests_failed++; $display("FAIL abort_we: got %b want 0", rf_we); end
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL abort_ready: got %b want 1", req_ready); end
        tests_run++; if (result !== 8'h00) begin tests_failed++; $display("FAIL abort_result: got %h want 00", result); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (done === 1'b1) done_cnt++;
        end
        $display("[TB] reset in WB -> r6=%h done_pulses=%0d", mem[6], done_cnt);
        tests_run++; if (done_cnt !== 0) begin tests_failed++; $display("FAIL abort_done: got %0d pulses want 0", done_cnt); end
        tests_run++; if (mem[6] !== 8'h11) begin tests_failed++; $display("FAIL abort_r6: got %h want 11", mem[6]); end
    endtask

`ifdef RMW_NOWB_EN
    task automatic test_nowb;
        int lat, wc;
        preload(4'd1, 8'h3C);
        preload(4'd2, 8'h3C);
        req_nowb = 1'b1;
        run_op(3'd4, 4'd1, 4'd2, 4'd1, 8'h00, lat, wc);
        req_nowb = 1'b0;
        $display("[TB] XOR nowb r1=3C -> r1=%h z=%b lat=%0d we_cycles=%0d", mem[1], flag_z, lat, wc);
        tests_run++; if (lat !== 4) begin tests_failed++; $display("FAIL nowb_done: got latency %0d want 4", lat); end
        tests_run++; if (flag_z !== 1'b1) begin tests_failed++; $display("FAIL nowb_z: got %b want 1", flag_z); end
        tests_run++; if (mem[1] !== 8'h3C) begin tests_failed++; $display("FAIL nowb_r1: got %h want 3C", mem[1]); end
        tests_run++; if (wc !== 0) begin tests_failed++; $display("FAIL nowb_we: got %0d cycles want 0", wc); end
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_shr_hazard();
        test_back_to_back();
        test_movi_seq();
        test_reset_in_wb();
`ifdef RMW_NOWB_EN
        test_nowb();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/reg_rmw_seq.md
Name: reg_rmw_seq

Overview:
Read-modify-write sequencer that sits directly upstream of the single-port register file (reg_inst) and drives its we/addr/din port. It consumes the register file's registered read data.
- Accepts one operation request at a time.
- Reads two source registers in turn, computes an 8-op ALU result, and writes the result back to a destination register.
- Reports completion together with zero/carry flags.

Parameters:
BIT, 8, data width; must match the register file's BIT.
SZB, 4, register address width; must match the register file's SZB.

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
req_valid  input  1  request present.
req_ready  output  1  high only in IDLE; a request is accepted when req_valid && req_ready at a clock edge.
req_op  input  3  opcode.
req_rs_a  input  SZB  source A address.
req_rs_b  input  SZB  source B address.
req_rd  input  SZB  destination address.
req_imm  input  BIT  immediate operand (MOVI).
rf_we  output  1  register file write enable.
rf_addr  output  SZB  register file address.
rf_din  output  BIT  register file write data.
rf_dout  input  BIT  register file read data; valid one cycle after the address is presented with we=0.
done  output  1  one-cycle pulse during the write-back cycle.
result  output  BIT  last computed result.
flag_z  output  1  result == 0.
flag_c  output  1  carry/borrow/shift-out.

Behaviour:
- Clock and reset:
  - One clock. Reset is synchronous and active-high.
  - Reset sets state=IDLE and clears all latched fields, result, flag_z and flag_c to 0.
  - After reset: req_ready=1, rf_we=0, rf_addr=0, rf_din=0, done=0.
- FSM states: IDLE, RD_A, RD_B, EXEC, WB. rf_we, rf_addr, rf_din, done and req_ready are combinational decodes of state and the latched fields.
  - IDLE: rf_we=0, rf_addr=0, rf_din=0. On acceptance, latch op/rs_a/rs_b/rd/imm and go to RD_A.
  - RD_A: rf_addr=rs_a, rf_we=0. Next state is RD_B.
  - RD_B: rf_addr=rs_b, rf_we=0. Capture opa<=rf_dout (the value of rs_a). Next state is EXEC.
  - EXEC: rf_addr=rs_b, rf_we=0. Compute from opa and rf_dout (the value of rs_b) and register result, flag_z and flag_c. Next state is WB.
  - WB: rf_we=1, rf_addr=rd, rf_din=result, done=1. Next state is IDLE.
- Latency and throughput:
  - Acceptance edge to WB cycle is 4 cycles. The write lands on the WB→IDLE edge.
  - Throughput is one operation per 5 cycles.
- Opcodes (all results truncated to BIT bits):
  - 0 ADD: result=A+B; c=carry out.
  - 1 SUB: result=A−B; c=1 iff A<B (unsigned borrow).
  - 2 AND, 3 OR, 4 XOR: c=0.
  - 5 SHL1: result=A<<1; c=A[BIT−1].
  - 6 SHR1: result=A>>1 (logical); c=A[0].
  - 7 MOVI: result=imm; c=0. B is still read, giving fixed latency.
- Flags: flag_z = (result==0). result and flags hold until the next EXEC edge.
- Boundary conditions:
  - Hazards: both reads complete before the write, so rd==rs_a or rd==rs_b uses the old values.
  - req_valid is ignored outside IDLE. Request inputs may change freely after acceptance.
  - Reset mid-operation aborts immediately: no write is issued and no done pulse occurs, even if reset is asserted in WB.

Optional Feature:
Macro RMW_NOWB_EN.
- Defined: adds input port req_nowb (1 bit), latched at acceptance. When the latched bit is 1, WB holds rf_we=0 (compare/test semantics); done, result and flags still update normally.
- Undefined: the port is absent and every operation writes back.

Decomposition:
- Shared definitions file holds:
  - opcode encodings OP_ADD..OP_MOVI (3 bits);
  - FSM state encodings;
  - the existing `OFF`/`BIT_DATA` constants.
- One combinational sub-module, rmw_alu. Inputs: op, a, b, imm. Outputs: result, carry. It is instantiated in EXEC datapath logic.

Test Plan:
- Reset, then preload the regfile with r1=0x80 and r2=0x80 via a backdoor or an earlier MOVI. Request ADD rs_a=1, rs_b=2, rd=3 → done 4 cycles after acceptance, r3=0x00, flag_z=1, flag_c=1.
- SUB with r1=0x05, r2=0x07, rd=4 → r4=0xFE, flag_c=1, flag_z=0. SUB with r1=r2=0x07 → result 0x00, z=1, c=0.
- SHR1 with r5=0x03, rd=5 (rd==rs_a) → r5=0x01, c=1. Back-to-back request held valid → second acceptance only after return to IDLE, 5 cycles apart.
- MOVI imm=0xA5, rd=15 → r15=0xA5. Check rf_addr sequence 0→rs_a→rs_b→rs_b→15, with rf_we high in exactly one cycle.
- Reset asserted in the WB cycle of ADD into r6 (initially 0x11) → r6 stays 0x11, no done pulse, req_ready=1 the cycle after reset deasserts.
- With RMW_NOWB_EN defined: XOR r1=0x3C, r2=0x3C, rd=1, req_nowb=1 → done pulses, flag_z=1, r1 unchanged at 0x3C, rf_we never asserted.
